output_deskew_buffer: RTL
=========================

Name: output_deskew_buffer

Overview:
- Drain-side counterpart of the array's input skew stage.
- Result lanes leave the systolic array staggered: lane i arrives i cycles after lane 0.
- This block delays each lane so that all N lanes of a row line up again.
- Each aligned row is pushed into a small FIFO, which drives a valid/ready stream to the writeback logic and tags the last row of every N-row tile.

Parameters:
- N, 4, number of lanes (array dimension); must be >= 1.
- DATA_WIDTH, 32, width of one result lane (accumulator width).
- FIFO_DEPTH, 8, number of aligned rows buffered; must be a power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush: empties the delay lines, valid pipe and FIFO, clears the row counter and overflow.
- enable  input  1  advances the delay lines and valid pipe; freezes them when low.
- skewed_input  input  N*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- skewed_valid  input  1  qualifies lane 0 this cycle. The matching lane-i word arrives i enabled cycles later.
- aligned_output  output  N*DATA_WIDTH  FIFO head row, in the same lane packing as the input.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head row.
- out_last  output  1  head row is row N-1 of its tile.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  number of occupied entries.
- overflow  output  1  sticky flag: an aligned row was dropped.

Behaviour:
- Reset (reset_n low, asynchronous) clears everything:
  - all delay registers, the valid pipe and the row counter go to 0;
  - the FIFO is emptied and its storage read as 0;
  - aligned_output=0, out_valid=0, out_last=0, fifo_count=0, overflow=0.
  - Reset asserted mid-stream discards all in-flight and buffered rows.
- Delay lines:
  - Lane i passes through N-1-i registers, each updating only when enable=1.
  - Lane N-1 has zero delay.
  - skewed_valid passes through an N-1-stage enable-gated pipe: aligned_valid is the pipe's last stage, or skewed_valid itself when N=1.
- Write condition: a write occurs on an edge where enable=1 and aligned_valid=1.
  - The row written is the outputs of lanes 0..N-2's last delay stages, concatenated with lane N-1's current input.
  - With enable held high, the row whose lane 0 is sampled at edge t is written at edge t+N-1. out_valid rises after that edge if the FIFO was empty.
- enable=0:
  - no shifting and no writes;
  - the FIFO read side still operates.
- Row counter (0..N-1):
  - increments on each accepted write and wraps N-1 -> 0;
  - the entry written while the counter is N-1 carries last=1 into the FIFO alongside the data.
- Read side:
  - First-word-fall-through: aligned_output and out_last always reflect the head entry.
  - A pop occurs when out_valid && out_ready.
  - When empty, aligned_output and out_last hold their last driven values; these are don't-care to the consumer.
- Full FIFO:
  - A write with no simultaneous pop is dropped: FIFO contents unchanged, row counter not advanced, overflow set.
  - A write with a simultaneous pop is accepted; count stays unchanged.
- Empty FIFO:
  - out_ready is ignored;
  - a write makes out_valid high on the next cycle; there is no combinational bypass.
- Simultaneous push and pop with a non-empty FIFO: count is unchanged, pointers advance, and wrap-around is modulo FIFO_DEPTH.
- fifo_count is registered and equals writes minus pops.
- clear=1 acts on the next edge like reset, but synchronously. clear takes priority over any same-cycle write or pop.
- overflow stays high until reset or clear.

Test Plan:
- Full tile alignment:
  - Setup: N=4; feed a skewed 4x4 tile with lane i of row r = 16*r+i, lane i delayed i cycles; enable=1; out_ready=1.
  - Required response: 4 rows emerge {0,1,2,3}, {16,17,18,19}, {32,33,34,35}, {48,49,50,51}; first out_valid appears 3 edges after the first skewed_valid edge; out_last=1 only on the 48.. row.
- Enable stall:
  - Stimulus: same tile, with enable dropped for 2 cycles mid-tile.
  - Required response: identical rows in identical order; row writes shift by exactly 2 cycles; no lane mixing.
- Overflow and backpressure:
  - Stimulus: FIFO_DEPTH=8, out_ready=0; stream 3 tiles (12 rows).
  - Required response: fifo_count saturates at 8; overflow=1 after the 9th aligned row; then raise out_ready and read exactly rows 0..7 with out_last on rows 3 and 7.
- Full with simultaneous pop:
  - Stimulus: fill the FIFO to 8, then assert out_ready=1 on the same edge as a write.
  - Required response: write accepted; fifo_count stays 8; overflow remains 0.
- Pointer wrap:
  - Stimulus: stream 20 rows with out_ready toggling 1/0 every cycle.
  - Required response: all 20 rows delivered in order; fifo_count never exceeds 8; out_last on every 4th row.
- Reset and clear:
  - Stimulus: assert reset_n=0 asynchronously between edges with 5 rows buffered and 2 in flight.
  - Required response: immediately out_valid=0, fifo_count=0, overflow=0, aligned_output=0; the next tile aligns from row counter 0.
  - Repeat with clear=1 for one cycle: same state one edge later.

Source files
------------

// File: rtl/output_deskew_buffer.sv
// rtl/output_deskew_buffer.sv - realigns staggered systolic result lanes into rows and buffers them in a FWFT FIFO
module output_deskew_buffer #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clear,
    input  logic                             enable,
    input  logic [N*DATA_WIDTH-1:0]          skewed_input,
    input  logic                             skewed_valid,
    output logic [N*DATA_WIDTH-1:0]          aligned_output,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic [N*DATA_WIDTH-1:0] row_data;
    logic                    aligned_valid;

    // Lane i gets N-1-i stages so that every lane reaches the row at the same edge as lane N-1.
    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int D = N - 1 - i;
        if (D == 0) begin : g_direct
            assign row_data[i*DATA_WIDTH +: DATA_WIDTH] = skewed_input[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] stage [D];

            // Enable-gated shift register for this lane.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < D; k++) stage[k] <= '0;
                end else if (clear) begin
                    for (int k = 0; k < D; k++) stage[k] <= '0;
                end else if (enable) begin
                    stage[0] <= skewed_input[i*DATA_WIDTH +: DATA_WIDTH];
                    for (int k = 1; k < D; k++) stage[k] <= stage[k-1];
                end
            end

            assign row_data[i*DATA_WIDTH +: DATA_WIDTH] = stage[D-1];
        end
    end

    // The valid flag rides along with lane 0 so it lands on the same edge as the complete row.
    if (N > 1) begin : g_vpipe
        logic vpipe [N-1];

        // Enable-gated valid pipe matching lane 0's delay.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k < N - 1; k++) vpipe[k] <= 1'b0;
            end else if (clear) begin
                for (int k = 0; k < N - 1; k++) vpipe[k] <= 1'b0;
            end else if (enable) begin
                vpipe[0] <= skewed_valid;
                for (int k = 1; k < N - 1; k++) vpipe[k] <= vpipe[k-1];
            end
        end

        assign aligned_valid = vpipe[N-2];
    end else begin : g_novpipe
        assign aligned_valid = skewed_valid;
    end

    logic [N*DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   mem_last;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [RW-1:0]           row_cnt;
    logic [N*DATA_WIDTH-1:0] hold_data;
    logic                    hold_last;
    logic                    write_req;
    logic                    pop;
    logic                    full;
    logic                    accept;
    logic                    drop;
    logic                    row_last;

    // Write/read handshakes; a full FIFO only takes a row if the head leaves on the same edge.
    always_comb begin
        out_valid = (fifo_count != '0);
        write_req = enable && aligned_valid;
        pop       = out_valid && out_ready;
        full      = (fifo_count == CW'(FIFO_DEPTH));
        accept    = write_req && (!full || pop);
        drop      = write_req && full && !pop;
        row_last  = (row_cnt == RW'(N - 1));
    end

    // FIFO storage: row data plus the end-of-tile tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) mem_data[k] <= '0;
            mem_last <= '0;
        end else if (clear) begin
            for (int k = 0; k < FIFO_DEPTH; k++) mem_data[k] <= '0;
            mem_last <= '0;
        end else if (accept) begin
            mem_data[wr_ptr] <= row_data;
            mem_last[wr_ptr] <= row_last;
        end
    end

    // Pointers, occupancy, tile row counter, sticky overflow and the empty-time output hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            row_cnt    <= '0;
            overflow   <= 1'b0;
            hold_data  <= '0;
            hold_last  <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            row_cnt    <= '0;
            overflow   <= 1'b0;
            hold_data  <= '0;
            hold_last  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr  <= wr_ptr + AW'(1);
                row_cnt <= row_last ? '0 : row_cnt + RW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            if (out_valid) begin
                hold_data <= mem_data[rd_ptr];
                hold_last <= mem_last[rd_ptr];
            end
        end
    end

    // First-word-fall-through head; when empty, keep showing the last head seen.
    always_comb begin
        aligned_output = out_valid ? mem_data[rd_ptr] : hold_data;
        out_last       = out_valid ? mem_last[rd_ptr] : hold_last;
    end

endmodule
